uart_rx_port: RTL and testbench

UART receiver that turns the serial line back into bytes for the CPU's memory-mapped UART data port. It is the receiving end of the same 8N1 link our UART transmitter drives. It oversamples the asynchronous `rx` pin, recovers each frame with a counter-timed state machine, and holds the received byte in an output register until the core acknowledges it. Framing and overrun errors are reported as status flags.

---
 rtl/uart_rx_port.sv | 134 +++++++++++++
 tb/tb_uart_rx_port.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver: synchronizes rx, times each frame with a shared bit counter,
// and holds the received byte until the core acknowledges it.
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shift, shift_d;
    logic             rx_m, rx_s;
    logic             done, ferr;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_d;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + CNT_W'(1);
        idx_d   = idx;
        shift_d = shift;
        done    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // Mid-start-bit check rejects short glitches silently.
                if (cnt == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d        = '0;
                    shift_d[idx] = rx_s;
                    idx_d        = idx + 3'd1;
                    if (idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // Wait out a held-low line so it is not re-read as a start bit.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            if (rx_ack) overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at 16 clocks per bit: timing, errors, overrun, reset.
module tb_uart_rx_port;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int rises = 0, rise_cyc = -1;
    int ferrs = 0, ferr_cyc = -1, ferr_run = 0, ferr_max = 0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0, busy_seen = 1'b0;

    uart_rx_port #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: valid rising edges, frame_err pulses, busy activity.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rises++;
            rise_cyc = cyc;
        end
        prev_valid = rx_valid;
        if (frame_err) begin
            ferr_run++;
            if (!prev_ferr) begin
                ferrs++;
                ferr_cyc = cyc;
            end
        end else begin
            ferr_run = 0;
        end
        if (ferr_run > ferr_max) ferr_max = ferr_run;
        prev_ferr = frame_err;
        if (busy) busy_seen = 1'b1;
    end

    // Called and returns at a negedge; 16 cycles per bit, start/data LSB first/stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int fall);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        fall = cyc;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int f, r0, e0;
        r0 = rises; e0 = ferrs;
        send_frame(8'hA5, 1'b1, f);
        checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL single_rises got=%0d exp=1", rises - r0); end
        checks++; if (rise_cyc - f !== 155) begin failures++; $display("FAIL single_latency got=%0d exp=155", rise_cyc - f); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rx_data); end
        checks++; if (ferrs - e0 !== 0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", ferrs - e0); end
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_ack_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_ack_data got=%h exp=a5", rx_data); end
    endtask

    task automatic test_glitch();
        int r0, e0;
        r0 = rises; e0 = ferrs;
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_pulse got=%b exp=1", busy_seen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", busy); end
        checks++; if (rises - r0 !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", rises - r0); end
        checks++; if (ferrs - e0 !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferrs - e0); end
    endtask

    task automatic test_frame_err();
        int f, r0, e0;
        r0 = rises; e0 = ferrs; ferr_max = 0;
        send_frame(8'h3C, 1'b0, f);
        repeat (40) @(negedge clk);
        checks++; if (ferrs - e0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferrs - e0); end
        checks++; if (ferr_max !== 1) begin failures++; $display("FAIL ferr_width got=%0d exp=1", ferr_max); end
        checks++; if (ferr_cyc - f !== 155) begin failures++; $display("FAIL ferr_time got=%0d exp=155", ferr_cyc - f); end
        checks++; if (rises - r0 !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", rises - r0); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_break_busy got=%b exp=1", busy); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_break_exit got=%b exp=0", busy); end
        repeat (16) @(negedge clk);
        send_frame(8'h11, 1'b1, f);
        checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL ferr_next_rise got=%0d exp=1", rises - r0); end
        checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ferr_next_data got=%h exp=11", rx_data); end
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic test_overrun();
        int f;
        send_frame(8'h01, 1'b1, f);
        send_frame(8'h02, 1'b1, f);
        checks++; if (rx_data !== 8'h01) begin failures++; $display("FAIL ovr_data got=%h exp=01", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_ack_valid got=%b exp=0", rx_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack_flag got=%b exp=0", overrun); end
    endtask

    task automatic test_ack_collide();
        int f, r0;
        send_frame(8'h55, 1'b1, f);
        r0 = rises;
        fork
            send_frame(8'hAA, 1'b1, f);
            begin
                repeat (154) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        checks++; if (rx_data !== 8'hAA) begin failures++; $display("FAIL collide_data got=%h exp=aa", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL collide_valid got=%b exp=1", rx_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL collide_overrun got=%b exp=0", overrun); end
        checks++; if (rises - r0 !== 0) begin failures++; $display("FAIL collide_valid_dropped got=%0d exp=0", rises - r0); end
    endtask

    task automatic test_reset_mid();
        int f, r0;
        fork
            send_frame(8'hFF, 1'b1, f);
            begin
                repeat (70) @(negedge clk);
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", rx_data); end
                checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
                checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
                checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
                r0 = rises;
            end
        join
        repeat (20) @(negedge clk);
        checks++; if (rises - r0 !== 0) begin failures++; $display("FAIL rstmid_spurious got=%0d exp=0", rises - r0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
        send_frame(8'h81, 1'b1, f);
        checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL rstmid_next_rise got=%0d exp=1", rises - r0); end
        checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL rstmid_next_data got=%h exp=81", rx_data); end
        checks++; if (rise_cyc - f !== 155) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=155", rise_cyc - f); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_ack_collide();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
